// File: rtl/iq_pkg.sv
// Shared widths and selection helpers for the wakeup issue queue.
// Helpers operate on MAX_Q-wide vectors; callers size-cast in and out.
package iq_pkg;
    localparam int INST_W = 32;
    localparam int VAL_W  = 64;
    localparam int PC_W   = 64;
    localparam int MAX_Q  = 64;

    // One-hot of the lowest set bit (lowest free slot when fed ~valid).
    function automatic logic [MAX_Q-1:0] lowest_free(input logic [MAX_Q-1:0] v);
        return v & (~v + MAX_Q'(1));
    endfunction

    // Entry i wins when it is ready and no ready entry is older than it.
    function automatic logic oldest_ready(input logic rdy_i,
                                          input logic [MAX_Q-1:0] rdy,
                                          input logic [MAX_Q-1:0] older_than_i);
        return rdy_i && ((rdy & older_than_i) == '0);
    endfunction
endpackage

// File: rtl/iq_age_select.sv
// Age matrix for the issue queue: tracks relative insertion order and
// produces a one-hot pick of the oldest ready entry.
module iq_age_select
    import iq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         ins,
    input  logic [N-1:0] ins_oh,
    input  logic [N-1:0] valid,
    input  logic [N-1:0] ready,
    output logic [N-1:0] sel_oh
);
    // older[i][j] = 1 when entry i was inserted before entry j
    logic [N-1:0] older [N];
    logic [N-1:0] col   [N];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < N; i++) older[i] <= '0;
        end else if (ins) begin
            for (int i = 0; i < N; i++) begin
                if (ins_oh[i])     older[i] <= '0;
                else if (valid[i]) older[i] <= older[i] | ins_oh;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            col[i] = '0;
            for (int j = 0; j < N; j++) col[i][j] = older[j][i];
        end
        sel_oh = '0;
        for (int i = 0; i < N; i++)
            sel_oh[i] = oldest_ready(ready[i], MAX_Q'(ready), MAX_Q'(col[i]));
    end
endmodule

// File: rtl/wakeup_issue_queue.sv
// Single-FU issue queue with multi-port operand wakeup, dispatch bypass,
// age-ordered select and flush.
module wakeup_issue_queue
    import iq_pkg::*;
#(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int QUEUE_SIZE   = 8,
    parameter int NUM_RESULTS  = 2,
    parameter int CNT_BITS     = $clog2(QUEUE_SIZE+1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             dispatch_valid,
    output logic                             dispatch_ready,
    input  logic [INST_ID_BITS-1:0]          dispatch_inst_id,
    input  logic [INST_W-1:0]                dispatch_inst,
    input  logic [MAX_OPERANDS-1:0]          dispatch_op_used,
    input  logic [MAX_OPERANDS*PRN_BITS-1:0] dispatch_op_prn,
    input  logic [MAX_OPERANDS-1:0]          dispatch_op_ready,
    input  logic [MAX_OPERANDS*VAL_W-1:0]    dispatch_op_value,
    input  logic [MAX_OPERANDS*PRN_BITS-1:0] dispatch_out_prn,
    input  logic [PC_W-1:0]                  dispatch_pc,
    input  logic [NUM_RESULTS-1:0]           result_valid,
    input  logic [NUM_RESULTS*PRN_BITS-1:0]  result_prn,
    input  logic [NUM_RESULTS*VAL_W-1:0]     result_value,
    output logic                             issue_valid,
    input  logic                             issue_ready,
    output logic [INST_ID_BITS-1:0]          issue_inst_id,
    output logic [INST_W-1:0]                issue_inst,
    output logic [MAX_OPERANDS*VAL_W-1:0]    issue_op,
    output logic [MAX_OPERANDS*PRN_BITS-1:0] issue_out_prn,
    output logic [PC_W-1:0]                  issue_pc,
    output logic [CNT_BITS-1:0]              count
);
    localparam int M = MAX_OPERANDS;

    typedef struct packed {
        logic                used;
        logic                rdy;
        logic [PRN_BITS-1:0] prn;
        logic [VAL_W-1:0]    value;
    } op_t;

    typedef struct packed {
        logic                         valid;
        logic [INST_ID_BITS-1:0]      inst_id;
        logic [INST_W-1:0]            inst;
        op_t [M-1:0]                  ops;
        logic [M-1:0][PRN_BITS-1:0]   out_prn;
        logic [PC_W-1:0]              pc;
    } entry_t;

    entry_t q     [QUEUE_SIZE];
    entry_t q_nxt [QUEUE_SIZE];
    entry_t disp_e;

    logic [QUEUE_SIZE-1:0] valid_v, ready_v, free_oh, sel_oh;
    logic [CNT_BITS-1:0]   cnt;
    logic                  full, do_disp, do_issue;

    // {hit, value}; iterating downward lets the lowest matching port win.
    function automatic logic [VAL_W:0] bcast(input logic [PRN_BITS-1:0] prn,
                                             input logic [NUM_RESULTS-1:0] rv,
                                             input logic [NUM_RESULTS*PRN_BITS-1:0] rp,
                                             input logic [NUM_RESULTS*VAL_W-1:0] rval);
        logic [VAL_W:0] r;
        r = '0;
        for (int p = NUM_RESULTS-1; p >= 0; p--)
            if (rv[p] && rp[p*PRN_BITS +: PRN_BITS] == prn)
                r = {1'b1, rval[p*VAL_W +: VAL_W]};
        return r;
    endfunction

    assign full           = (cnt == CNT_BITS'(QUEUE_SIZE));
    assign dispatch_ready = !full;
    assign do_disp        = dispatch_valid && !full && !flush;
    assign issue_valid    = |sel_oh;
    assign do_issue       = issue_valid && issue_ready && !flush;
    assign free_oh        = QUEUE_SIZE'(lowest_free(MAX_Q'(~valid_v)));
    assign count          = cnt;

    always_comb begin
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            valid_v[i] = q[i].valid;
            ready_v[i] = q[i].valid;
            for (int o = 0; o < M; o++) ready_v[i] = ready_v[i] && q[i].ops[o].rdy;
        end
    end

    always_comb begin
        logic [VAL_W:0] b;
        b              = '0;
        disp_e         = '0;
        disp_e.valid   = 1'b1;
        disp_e.inst_id = dispatch_inst_id;
        disp_e.inst    = dispatch_inst;
        disp_e.pc      = dispatch_pc;
        for (int o = 0; o < M; o++) begin
            disp_e.out_prn[o]  = dispatch_out_prn[o*PRN_BITS +: PRN_BITS];
            disp_e.ops[o].used = dispatch_op_used[o];
            disp_e.ops[o].prn  = dispatch_op_prn[o*PRN_BITS +: PRN_BITS];
            if (!dispatch_op_used[o]) begin
                disp_e.ops[o].rdy = 1'b1;
            end else if (dispatch_op_ready[o]) begin
                disp_e.ops[o].rdy   = 1'b1;
                disp_e.ops[o].value = dispatch_op_value[o*VAL_W +: VAL_W];
            end else begin
                b = bcast(disp_e.ops[o].prn, result_valid, result_prn, result_value);
                disp_e.ops[o].rdy   = b[VAL_W];
                disp_e.ops[o].value = b[VAL_W-1:0];
            end
        end
    end

    always_comb begin
        logic [VAL_W:0] b;
        b = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            q_nxt[i] = q[i];
            for (int o = 0; o < M; o++) begin
                if (q[i].valid && q[i].ops[o].used && !q[i].ops[o].rdy) begin
                    b = bcast(q[i].ops[o].prn, result_valid, result_prn, result_value);
                    if (b[VAL_W]) begin
                        q_nxt[i].ops[o].rdy   = 1'b1;
                        q_nxt[i].ops[o].value = b[VAL_W-1:0];
                    end
                end
            end
            if (do_issue && sel_oh[i]) q_nxt[i].valid = 1'b0;
            if (do_disp && free_oh[i]) q_nxt[i] = disp_e;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < QUEUE_SIZE; i++) q[i] <= '0;
            cnt <= '0;
        end else begin
            for (int i = 0; i < QUEUE_SIZE; i++) q[i] <= q_nxt[i];
            case ({do_disp, do_issue})
                2'b10:   cnt <= cnt + CNT_BITS'(1);
                2'b01:   cnt <= cnt - CNT_BITS'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    iq_age_select #(.N(QUEUE_SIZE)) u_age (
        .clk    (clk),
        .rst    (rst),
        .clear  (flush),
        .ins    (do_disp),
        .ins_oh (free_oh),
        .valid  (valid_v),
        .ready  (ready_v),
        .sel_oh (sel_oh)
    );

    // One-hot select makes an OR-reduce mux; all zero when nothing is ready.
    always_comb begin
        issue_inst_id = '0;
        issue_inst    = '0;
        issue_op      = '0;
        issue_out_prn = '0;
        issue_pc      = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            if (sel_oh[i]) begin
                issue_inst_id = issue_inst_id | q[i].inst_id;
                issue_inst    = issue_inst | q[i].inst;
                issue_pc      = issue_pc | q[i].pc;
                for (int o = 0; o < M; o++) begin
                    issue_op[o*VAL_W +: VAL_W]         = issue_op[o*VAL_W +: VAL_W] | q[i].ops[o].value;
                    issue_out_prn[o*PRN_BITS +: PRN_BITS] = issue_out_prn[o*PRN_BITS +: PRN_BITS] | q[i].out_prn[o];
                end
            end
        end
    end
endmodule
